// File: rtl/register_bank_pkg.sv
// Shared address-map helpers and byte-merge for register_bank.
package register_bank_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / BYTE_W;

  function automatic int rw_addr(int num_ro, int idx);
    return num_ro + idx;
  endfunction

  function automatic int status_addr(int num_ro, int num_rw);
    return num_ro + num_rw;
  endfunction

  function automatic int mask_addr(int num_ro, int num_rw);
    return status_addr(num_ro, num_rw) + 1;
  endfunction

  // Width-agnostic: callers zero-extend into MAX_DW and truncate the result back.
  function automatic logic [MAX_DW-1:0] byte_merge(logic [MAX_DW-1:0] old_w,
                                                    logic [MAX_DW-1:0] new_w,
                                                    logic [MAX_BE-1:0] byte_en);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_BE; b++)
      if (byte_en[b]) r[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
    return r;
  endfunction

endpackage

// File: rtl/register_bank_event_status.sv
// Sticky event-status bits: rising-edge set, write-1-to-clear, set beats clear.
module register_bank_event_status
  import register_bank_pkg::*;
#(
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic [NUM_EVENTS-1:0] clr,
  output logic [NUM_EVENTS-1:0] status
);

  logic [NUM_EVENTS-1:0] hist_q, hist_d;
  logic [NUM_EVENTS-1:0] status_q, status_d;

  always_comb begin
    hist_d   = events;
    status_d = (status_q & ~clr) | (events & ~hist_q);
  end

  // History clears with reset so a level already high counts as an edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '0;
      status_q <= '0;
    end else begin
      hist_q   <= hist_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;

endmodule

// File: rtl/register_bank.sv
// Parametrised memory-mapped register bank: RO inputs, RW outputs with strobes, W1C event status.
// Optional mask register and interrupt output enabled by defining REGISTER_BANK_IRQ_EN.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RO     = 4,
  parameter int NUM_RW     = 4,
  parameter int NUM_EVENTS = 8,
  parameter logic [NUM_RW*DATA_WIDTH-1:0] RW_RESET = '0
) (
  input  logic                         ipClk,
  input  logic                         ipReset,
  input  logic [NUM_RO*DATA_WIDTH-1:0] ipRdRegisters,
  output logic [NUM_RW*DATA_WIDTH-1:0] opWrRegisters,
  output logic [NUM_RW-1:0]            opWrStrobe,
  input  logic [NUM_EVENTS-1:0]        ipEvents,
  output logic                         opIrq,
  input  logic [ADDR_WIDTH-1:0]        ipAddress,
  input  logic [DATA_WIDTH-1:0]        ipWrData,
  input  logic [DATA_WIDTH/8-1:0]      ipWrByteEn,
  input  logic                         ipWrEnable,
  input  logic                         ipRdEnable,
  output logic [DATA_WIDTH-1:0]        opRdData,
  output logic                         opRdValid
);

  localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(status_addr(NUM_RO, NUM_RW));
  localparam logic [ADDR_WIDTH-1:0] MASK_A   = ADDR_WIDTH'(mask_addr(NUM_RO, NUM_RW));

  logic reset_q;
  always_ff @(posedge ipClk) reset_q <= ipReset;

  logic wr_ok, rd_ok;
  assign wr_ok = ipWrEnable & ~reset_q;
  assign rd_ok = ipRdEnable & ~reset_q;

  logic [DATA_WIDTH-1:0] wmask;
  assign wmask = DATA_WIDTH'(byte_merge('0, '1, MAX_BE'(ipWrByteEn)));

  logic [NUM_RW-1:0][DATA_WIDTH-1:0] rw_q, rw_d;
  logic [NUM_RW-1:0]                 strobe_q, strobe_d;

  always_comb begin
    rw_d     = rw_q;
    strobe_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (wr_ok && ipAddress == ADDR_WIDTH'(rw_addr(NUM_RO, i))) begin
        rw_d[i]     = DATA_WIDTH'(byte_merge(MAX_DW'(rw_q[i]), MAX_DW'(ipWrData),
                                             MAX_BE'(ipWrByteEn)));
        strobe_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (reset_q) begin
      rw_q     <= RW_RESET;
      strobe_q <= '0;
    end else begin
      rw_q     <= rw_d;
      strobe_q <= strobe_d;
    end
  end

  assign opWrRegisters = rw_q;
  assign opWrStrobe    = strobe_q;

  logic [NUM_EVENTS-1:0] status, status_clr;
  assign status_clr = (wr_ok && ipAddress == STATUS_A) ? NUM_EVENTS'(ipWrData & wmask) : '0;

  register_bank_event_status #(.NUM_EVENTS(NUM_EVENTS)) u_event_status (
    .clk    (ipClk),
    .rst    (reset_q),
    .events (ipEvents),
    .clr    (status_clr),
    .status (status)
  );

  logic [NUM_EVENTS-1:0] mask_rd;

`ifdef REGISTER_BANK_IRQ_EN
  logic [NUM_EVENTS-1:0] mask_q, mask_d;
  logic                  irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr_ok && ipAddress == MASK_A)
      mask_d = NUM_EVENTS'(byte_merge(MAX_DW'(mask_q), MAX_DW'(ipWrData), MAX_BE'(ipWrByteEn)));
    irq_d = |(status & mask_q);
  end

  always_ff @(posedge ipClk) begin
    if (reset_q) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd = mask_q;
  assign opIrq   = irq_q;
`else
  assign mask_rd = '0;
  assign opIrq   = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] rd_word, rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  // Mux reads current register state, so a same-cycle write is not yet visible.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_RO; i++)
      if (ipAddress == ADDR_WIDTH'(i)) rd_word = ipRdRegisters[i*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < NUM_RW; i++)
      if (ipAddress == ADDR_WIDTH'(rw_addr(NUM_RO, i))) rd_word = rw_q[i];
    if (ipAddress == STATUS_A) rd_word = DATA_WIDTH'(status);
    if (ipAddress == MASK_A)   rd_word = DATA_WIDTH'(mask_rd);
    rd_data_d  = rd_ok ? rd_word : rd_data_q;
    rd_valid_d = rd_ok;
  end

  always_ff @(posedge ipClk) begin
    if (reset_q) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign opRdData  = rd_data_q;
  assign opRdValid = rd_valid_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed vector bench for register_bank (default map: RO 0-3, RW 4-7, STATUS 8, MASK 9).
module tb_register_bank;

`ifdef REGISTER_BANK_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  localparam logic [127:0] RW_RST = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'hA5A5_0001};
  localparam logic [127:0] RO_VAL = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] rd_regs = RO_VAL;
  logic [127:0] wr_regs;
  logic [3:0]   stb;
  logic [7:0]   ev = '0;
  logic         irq;
  logic [7:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [3:0]   be = '0;
  logic         wr = 1'b0, rd = 1'b0;
  logic [31:0]  rdata;
  logic         rvld;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_bank #(.RW_RESET(RW_RST)) dut (
    .ipClk(clk), .ipReset(rst), .ipRdRegisters(rd_regs), .opWrRegisters(wr_regs),
    .opWrStrobe(stb), .ipEvents(ev), .opIrq(irq), .ipAddress(addr), .ipWrData(wdata),
    .ipWrByteEn(be), .ipWrEnable(wr), .ipRdEnable(rd), .opRdData(rdata), .opRdValid(rvld)
  );

  typedef struct {
    logic        wr, rd;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [7:0]  ev;
    logic        e_vld;
    logic [31:0] e_data;
    logic [3:0]  e_stb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic w, logic r, logic [7:0] a, logic [31:0] d, logic [3:0] b,
                             logic [7:0] e, logic ev_, logic [31:0] ed, logic [3:0] es);
    vec_t t;
    t.wr = w; t.rd = r; t.addr = a; t.wd = d; t.be = b; t.ev = e;
    t.e_vld = ev_; t.e_data = ed; t.e_stb = es;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic w, logic r, logic [7:0] a, logic [31:0] d, logic [3:0] b);
    wr = w; rd = r; addr = a; wdata = d; be = b;
  endtask

  initial begin
    // cols: wr rd addr wdata be ev | exp valid, exp data, exp strobe
    tbl.push_back(v(0, 1, 8'h04, 32'h0,         4'h0, 8'h00, 1, 32'hA5A5_0001, 4'h0));
    tbl.push_back(v(1, 0, 8'h04, 32'h0,         4'hF, 8'h00, 0, 32'hA5A5_0001, 4'h1));
    tbl.push_back(v(1, 0, 8'h04, 32'h1234_5678, 4'h5, 8'h00, 0, 32'hA5A5_0001, 4'h1));
    tbl.push_back(v(0, 1, 8'h04, 32'h0,         4'h0, 8'h00, 1, 32'h0034_0078, 4'h0));
    tbl.push_back(v(0, 0, 8'h00, 32'h0,         4'h0, 8'h00, 0, 32'h0034_0078, 4'h0));
    tbl.push_back(v(1, 0, 8'h05, 32'hFFFF_FFFF, 4'h0, 8'h00, 0, 32'h0034_0078, 4'h2));
    tbl.push_back(v(0, 1, 8'h05, 32'h0,         4'h0, 8'h00, 1, 32'h0000_0022, 4'h0));
    tbl.push_back(v(1, 0, 8'h00, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 32'h0000_0022, 4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'hFFFF_FFFF, 4'hF, 8'h00, 0, 32'h0000_0022, 4'h0));
    tbl.push_back(v(0, 1, 8'h00, 32'h0,         4'h0, 8'h00, 1, 32'hAAAA_0000, 4'h0));
    tbl.push_back(v(0, 1, 8'h01, 32'h0,         4'h0, 8'h00, 1, 32'hBBBB_0001, 4'h0));
    tbl.push_back(v(0, 1, 8'hFF, 32'h0,         4'h0, 8'h00, 1, 32'h0,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h00, 1, 32'h0,         4'h0));
    tbl.push_back(v(1, 1, 8'h07, 32'hCAFE_BABE, 4'hF, 8'h00, 1, 32'h0000_0044, 4'h8));
    tbl.push_back(v(0, 1, 8'h07, 32'h0,         4'h0, 8'h00, 1, 32'hCAFE_BABE, 4'h0));
    tbl.push_back(v(0, 1, 8'h09, 32'h0,         4'h0, 8'h00, 1, 32'h0,         4'h0));
    tbl.push_back(v(0, 1, 8'h0A, 32'h0,         4'h0, 8'h00, 1, 32'h0,         4'h0));
    tbl.push_back(v(0, 0, 8'h00, 32'h0,         4'h0, 8'h08, 0, 32'h0,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h08, 1, 32'h8,         4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'h8,         4'hF, 8'h08, 0, 32'h8,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h08, 1, 32'h0,         4'h0));
    tbl.push_back(v(0, 0, 8'h00, 32'h0,         4'h0, 8'h00, 0, 32'h0,         4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'h8,         4'h1, 8'h08, 0, 32'h0,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h08, 1, 32'h8,         4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'h8,         4'hE, 8'h00, 0, 32'h8,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h00, 1, 32'h8,         4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'h0,         4'hF, 8'h00, 0, 32'h8,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h00, 1, 32'h8,         4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'h8,         4'h1, 8'h00, 0, 32'h8,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h00, 1, 32'h0,         4'h0));
    tbl.push_back(v(0, 0, 8'h00, 32'h0,         4'h0, 8'h80, 0, 32'h0,         4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h80, 1, 32'h80,        4'h0));
    tbl.push_back(v(1, 0, 8'h08, 32'hFFFF_FFFF, 4'hF, 8'h80, 0, 32'h80,        4'h0));
    tbl.push_back(v(0, 1, 8'h08, 32'h0,         4'h0, 8'h00, 1, 32'h0,         4'h0));

    // Reset: one-cycle pulse, state settles one cycle later.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_rvld", 128'(rvld), 128'(1'b0));
    chk("rst_rdata", 128'(rdata), 128'(32'h0));
    chk("rst_stb", 128'(stb), 128'(4'h0));
    chk("rst_irq", 128'(irq), 128'(1'b0));
    chk("rst_rwregs", wr_regs, RW_RST);

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].be);
      ev = tbl[i].ev;
      tick();
      chk($sformatf("v%0d_rvld", i), 128'(rvld), 128'(tbl[i].e_vld));
      chk($sformatf("v%0d_rdata", i), 128'(rdata), 128'(tbl[i].e_data));
      chk($sformatf("v%0d_stb", i), 128'(stb), 128'(tbl[i].e_stb));
    end
    drive(0, 0, 8'h00, 32'h0, 4'h0);
    ev = 8'h00;
    tick();
    chk("rwregs_after_tbl", wr_regs,
        {32'hCAFE_BABE, 32'h0000_0033, 32'h0000_0022, 32'h0034_0078});

    // Mask register and interrupt.
    drive(1, 0, 8'h09, 32'hFFFF_FFFF, 4'hF); tick();
    drive(0, 1, 8'h09, 32'h0, 4'h0);         tick();
    chk("mask_rd", 128'(rdata), IRQ ? 128'(32'hFF) : 128'(32'h0));
    drive(1, 0, 8'h09, 32'h4, 4'hF);         tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0);
    ev = 8'h04;                              tick();
    chk("irq_pre", 128'(irq), 128'(1'b0));
    tick();
    chk("irq_set", 128'(irq), 128'(IRQ));
    drive(1, 0, 8'h08, 32'h4, 4'hF);         tick();
    chk("irq_hold", 128'(irq), 128'(IRQ));
    drive(0, 0, 8'h00, 32'h0, 4'h0);         tick();
    chk("irq_clr", 128'(irq), 128'(1'b0));
    drive(0, 1, 8'h08, 32'h0, 4'h0);         tick();
    chk("status_after_irq", 128'(rdata), 128'(32'h0));

    // Reset with an event level held high: request dropped, bit sets right after.
    ev = 8'h01;
    drive(0, 0, 8'h00, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 1, 8'h04, 32'hFFFF_FFFF, 4'hF);
    tick();
    chk("rst2_rvld", 128'(rvld), 128'(1'b0));
    chk("rst2_rdata", 128'(rdata), 128'(32'h0));
    chk("rst2_rwregs", wr_regs, RW_RST);
    chk("rst2_irq", 128'(irq), 128'(1'b0));
    drive(0, 0, 8'h00, 32'h0, 4'h0);
    tick();
    chk("rst2_stb", 128'(stb), 128'(4'h0));
    drive(0, 1, 8'h08, 32'h0, 4'h0);
    tick();
    chk("rst2_status", 128'(rdata), 128'(32'h1));
    chk("rst2_status_vld", 128'(rvld), 128'(1'b1));
    drive(0, 0, 8'h00, 32'h0, 4'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
